// File: rtl/cltu_block_framer_pkg.sv
// -----------------------------------------------------------------------------
// cltu_block_framer_pkg
// Shared definitions for the CLTU block framer: start sequence, BCH(63,56)
// generator polynomial, codeblock geometry, FSM state types and the one-bit
// LFSR step of the parity checker.
// -----------------------------------------------------------------------------
package cltu_block_framer_pkg;

  localparam logic [15:0] CLTU_START_SEQ = 16'hEB90;
  // g(x) = x^7 + x^6 + x^2 + 1 without the implicit x^7 term
  localparam logic [6:0]  BCH_POLY       = 7'h45;
  localparam int          CB_INFO_BITS   = 56;

  // Bit positions inside a 64-bit codeblock (0 = first received)
  localparam logic [5:0]  LAST_INFO_IDX  = 6'd55;
  localparam logic [5:0]  LAST_PAR_IDX   = 6'd62;
  localparam logic [5:0]  FILLER_IDX     = 6'd63;

  typedef enum logic {RX_SEARCH, RX_RECV} rx_state_e;
  typedef enum logic {TX_IDLE, TX_BURST}  tx_state_e;

  // One serial step of the remainder of info(x)*x^7 mod g(x), MSB first.
  function automatic logic [6:0] bch_step(input logic [6:0] rem, input logic b);
    logic fb;
    fb = b ^ rem[6];
    return {rem[5:0], 1'b0} ^ (fb ? BCH_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/cltu_block_framer_if.sv
// -----------------------------------------------------------------------------
// cltu_block_framer_if
// Bit-stream input and codeblock-burst output bundle of the CLTU block framer.
//   BitI/BitValidI   demodulated bit and its 1-cycle strobe (into the framer)
//   DataO/EnO        serial info burst to the codeblock receiver
//   Block_ErrO       parity error flag held for the current burst
//   CltuActiveO      high while the framer is inside a CLTU
//   OverrunO         1-cycle pulse: completed block dropped, burst still busy
//   BlockCntO        good blocks in the current CLTU (wraps)
// slave = framer side, master = bit source / receiver side.
// -----------------------------------------------------------------------------
interface cltu_block_framer_if #(
  parameter int CNT_W = 16
);
  logic             BitI;
  logic             BitValidI;
  logic             DataO;
  logic             EnO;
  logic             Block_ErrO;
  logic             CltuActiveO;
  logic             OverrunO;
  logic [CNT_W-1:0] BlockCntO;

  modport master (
    output BitI, BitValidI,
    input  DataO, EnO, Block_ErrO, CltuActiveO, OverrunO, BlockCntO
  );

  modport slave (
    input  BitI, BitValidI,
    output DataO, EnO, Block_ErrO, CltuActiveO, OverrunO, BlockCntO
  );
endinterface

// File: rtl/cltu_block_framer_bch_63_56_chk.sv
// -----------------------------------------------------------------------------
// cltu_block_framer_bch_63_56_chk
// Serial BCH(63,56) remainder LFSR. Shifts one info bit per en_i, MSB first;
// clr_i (priority over en_i) zeroes the remainder.
//   clk, rst   clock, asynchronous active-high reset
//   clr_i      synchronous clear
//   en_i       consume bit_i
//   bit_i      info bit
//   rem_o      current remainder of info(x)*x^7 mod g(x)
// -----------------------------------------------------------------------------
module cltu_block_framer_bch_63_56_chk
  import cltu_block_framer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] rem_o
);

  logic [6:0] rem_q;

  // NOTE: clocked state is written with non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
    end else if (clr_i) begin
      rem_q <= '0;
    end else if (en_i) begin
      rem_q <= bch_step(rem_q, bit_i);
    end
  end

  assign rem_o = rem_q;

endmodule

// File: rtl/cltu_block_framer.sv
// -----------------------------------------------------------------------------
// cltu_block_framer
// Hunts the TC bitstream for the CLTU start sequence, frames 64-bit BCH(63,56)
// codeblocks (56 info + 7 parity + 1 filler), checks parity in detection-only
// mode and replays each block's info bits as a 56-clock burst. The first
// errored block (normally the CLTU tail) ends the CLTU.
//   ClkI, RstI   clock, asynchronous active-high reset
//   bus          cltu_block_framer_if.slave (bit input, burst output, status)
// -----------------------------------------------------------------------------
module cltu_block_framer
  import cltu_block_framer_pkg::*;
#(
  parameter logic [15:0] START_SEQ = CLTU_START_SEQ,
  parameter int          TIMEOUT   = 50000,
  parameter int          CNT_W     = 16
) (
  input  logic                ClkI,
  input  logic                RstI,
  cltu_block_framer_if.slave  bus
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  // rx side
  rx_state_e                 rx_state_q;
  logic [15:0]               win_q, win_d;
  logic [5:0]                bit_cnt_q;
  logic [CB_INFO_BITS-1:0]   info_q;
  logic [6:0]                par_q;
  logic [IDLE_W-1:0]         idle_q;
  logic [CNT_W-1:0]          blk_cnt_q;
  logic [CB_INFO_BITS-1:0]   outbuf_q;
  logic                      err_buf_q;
  logic                      req_q;
  logic                      overrun_q;
  // tx side
  tx_state_e                 tx_state_q;
  logic [5:0]                tx_cnt_q;
  logic [CB_INFO_BITS-1:0]   shift_q;
  logic                      en_q, data_q, berr_q;

  logic       in_recv, strobe, lfsr_clr, lfsr_en, blk_err, tx_busy;
  logic [6:0] rem;

  assign in_recv  = (rx_state_q == RX_RECV);
  assign strobe   = bus.BitValidI;
  assign win_d    = {win_q[14:0], bus.BitI};
  // Remainder is held at zero outside a CLTU and restarts after every block.
  assign lfsr_clr = !in_recv || (strobe && bit_cnt_q == FILLER_IDX);
  assign lfsr_en  = in_recv && strobe && (bit_cnt_q <= LAST_INFO_IDX);
  // Transmitted parity is the complemented remainder.
  assign blk_err  = (par_q != ~rem);
  // A request landing on the final burst cycle is accepted; tx picks it up
  // after one idle clock.
  assign tx_busy  = req_q || (tx_state_q == TX_BURST && tx_cnt_q != LAST_INFO_IDX);

  cltu_block_framer_bch_63_56_chk u_bch (
    .clk   (ClkI),
    .rst   (RstI),
    .clr_i (lfsr_clr),
    .en_i  (lfsr_en),
    .bit_i (bus.BitI),
    .rem_o (rem)
  );

  // NOTE: data buffers are reset along with control state so that a reset
  // mid-burst leaves no stale block behind and every output reads 0.
  always_ff @(posedge ClkI or posedge RstI) begin
    if (RstI) begin
      rx_state_q <= RX_SEARCH;
      win_q      <= '0;
      bit_cnt_q  <= '0;
      info_q     <= '0;
      par_q      <= '0;
      idle_q     <= '0;
      blk_cnt_q  <= '0;
      outbuf_q   <= '0;
      err_buf_q  <= 1'b0;
      req_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      req_q     <= 1'b0;
      overrun_q <= 1'b0;
      case (rx_state_q)
        RX_SEARCH: begin
          if (strobe) begin
            win_q <= win_d;
            if (win_d == START_SEQ) begin
              rx_state_q <= RX_RECV;
              bit_cnt_q  <= '0;
              idle_q     <= '0;
              blk_cnt_q  <= '0;
            end
          end
        end
        RX_RECV: begin
          if (strobe) begin
            idle_q    <= '0;
            bit_cnt_q <= bit_cnt_q + 6'd1;  // wraps 63 -> 0
            if (bit_cnt_q <= LAST_INFO_IDX) begin
              info_q <= {info_q[CB_INFO_BITS-2:0], bus.BitI};
            end else if (bit_cnt_q <= LAST_PAR_IDX) begin
              par_q <= {par_q[5:0], bus.BitI};
            end else begin
              // Filler bit: block complete.
              if (tx_busy) begin
                overrun_q <= 1'b1;
              end else begin
                outbuf_q  <= info_q;
                err_buf_q <= blk_err;
                req_q     <= 1'b1;
              end
              if (blk_err) begin
                rx_state_q <= RX_SEARCH;
                win_q      <= '0;
              end else begin
                blk_cnt_q <= blk_cnt_q + CNT_W'(1);
              end
            end
          end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            // Bit source went silent: drop the partial block and the CLTU.
            rx_state_q <= RX_SEARCH;
            win_q      <= '0;
            idle_q     <= '0;
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
          end
        end
        default: rx_state_q <= RX_SEARCH;
      endcase
    end
  end

  // Burst engine: copies the out buffer into its own shifter at burst start,
  // so the rx side may refill the buffer during the last burst cycle.
  always_ff @(posedge ClkI or posedge RstI) begin
    if (RstI) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      shift_q    <= '0;
      en_q       <= 1'b0;
      data_q     <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (req_q) begin
            tx_state_q <= TX_BURST;
            tx_cnt_q   <= '0;
            en_q       <= 1'b1;
            data_q     <= outbuf_q[CB_INFO_BITS-1];
            shift_q    <= {outbuf_q[CB_INFO_BITS-2:0], 1'b0};
            berr_q     <= err_buf_q;
          end
        end
        TX_BURST: begin
          if (tx_cnt_q == LAST_INFO_IDX) begin
            tx_state_q <= TX_IDLE;
            en_q       <= 1'b0;
            data_q     <= 1'b0;
            berr_q     <= 1'b0;
          end else begin
            tx_cnt_q <= tx_cnt_q + 6'd1;
            data_q   <= shift_q[CB_INFO_BITS-1];
            shift_q  <= {shift_q[CB_INFO_BITS-2:0], 1'b0};
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign bus.DataO       = data_q;
  assign bus.EnO         = en_q;
  assign bus.Block_ErrO  = berr_q;
  assign bus.CltuActiveO = in_recv;
  assign bus.OverrunO    = overrun_q;
  assign bus.BlockCntO   = blk_cnt_q;

endmodule

// File: tb/tb_cltu_block_framer.sv
// -----------------------------------------------------------------------------
// tb_cltu_block_framer
// Directed bench for cltu_block_framer: a table of codeblock vectors with
// expected burst contents and status, plus hand-written sequences for false
// start sequences, idle timeout, back-to-back blocks and reset mid-burst.
// -----------------------------------------------------------------------------
module tb_cltu_block_framer;

  localparam int TO = 300;  // shortened idle timeout for simulation

  logic ClkI;
  logic RstI;

  initial ClkI = 1'b0;
  always #5 ClkI = ~ClkI;

  cltu_block_framer_if #(.CNT_W(16)) bus ();

  cltu_block_framer #(
    .START_SEQ (16'hEB90),
    .TIMEOUT   (TO),
    .CNT_W     (16)
  ) dut (
    .ClkI (ClkI),
    .RstI (RstI),
    .bus  (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   en_rises = 0;
  int   ovr_cnt  = 0;
  logic en_prev  = 1'b0;

  // Output monitor, sampled away from the active edge.
  always @(negedge ClkI) begin
    if (bus.EnO === 1'b1 && en_prev !== 1'b1) en_rises <= en_rises + 1;
    if (bus.OverrunO === 1'b1) ovr_cnt <= ovr_cnt + 1;
    en_prev <= bus.EnO;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference remainder by polynomial long division of info(x)*x^7 by
  // g(x) = x^7+x^6+x^2+1 (8'hC5).
  function automatic logic [6:0] model_rem(input logic [55:0] info);
    logic [62:0] m;
    m = {info, 7'b0};
    for (int i = 62; i >= 7; i--) begin
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'hC5;
    end
    return m[6:0];
  endfunction

  // 64-bit codeblock, first-transmitted bit at [63]: info, ~rem, filler 0.
  function automatic logic [63:0] make_word(input logic [55:0] info, input logic [63:0] flip);
    return {info, ~model_rem(info), 1'b0} ^ flip;
  endfunction

  // Called on a negedge; returns on a negedge after gap idle clocks.
  task automatic send_bit(input logic b, input int gap);
    bus.BitI      = b;
    bus.BitValidI = 1'b1;
    @(negedge ClkI);
    bus.BitValidI = 1'b0;
    repeat (gap) @(negedge ClkI);
  endtask

  task automatic send_seq16(input logic [15:0] v, input int gap);
    for (int i = 15; i >= 0; i--) send_bit(v[i], gap);
  endtask

  task automatic send_block(input logic [63:0] w, input int gap, input int pause_at,
                            input int pause_len);
    for (int i = 0; i < 64; i++) send_bit(w[63-i], (i == pause_at) ? pause_len : gap);
  endtask

  // Waits (bounded) for EnO, collects 56 bits and checks the trailing idle clock.
  task automatic capture_burst(input string tag, input logic [55:0] exp_data,
                               input logic exp_err);
    int          w;
    int          len;
    int          err_ok;
    logic [55:0] got;
    w = 0;
    while (bus.EnO !== 1'b1 && w < 600) begin
      @(negedge ClkI);
      w++;
    end
    check({tag, "_start"}, bus.EnO, 1'b1);
    len = 0;
    err_ok = 0;
    got = '0;
    for (int i = 0; i < 56; i++) begin
      if (bus.EnO === 1'b1) len++;
      if (bus.Block_ErrO === exp_err) err_ok++;
      got = {got[54:0], bus.DataO};
      @(negedge ClkI);
    end
    check({tag, "_data"}, got, exp_data);
    check({tag, "_en_len"}, len, 56);
    check({tag, "_berr_held"}, err_ok, 56);
    check({tag, "_idle_after"}, {bus.EnO, bus.DataO, bus.Block_ErrO}, 3'b000);
  endtask

  typedef struct {
    string       name;
    bit          sync;
    logic [63:0] word;
    logic        exp_err;
    int          exp_cnt;
    logic        exp_active;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] tail_w;
  logic [63:0] good_w;
  logic [63:0] w7[3];
  int          r0;

  initial begin
    tail_w = 64'hC5C5_C5C5_C5C5_C579;
    good_w = make_word(56'h0123_4567_89AB_CD, 64'h0);
    vecs[0] = '{"good_block",   1'b1, good_w, 1'b0, 1, 1'b1};
    vecs[1] = '{"tail_1",       1'b0, tail_w, 1'b1, 1, 1'b0};
    // Stream bit 58 sits at word bit 63-58 = 5.
    vecs[2] = '{"par_bit58",    1'b1, make_word(56'hFF_FFFF_FFFF_FFFF, 64'h20), 1'b1, 0, 1'b0};
    vecs[3] = '{"zero_block",   1'b1, make_word(56'h0, 64'h0), 1'b0, 1, 1'b1};
    vecs[4] = '{"a5_block",     1'b0, make_word(56'hA5_A5A5_A5A5_A5A5, 64'h0), 1'b0, 2, 1'b1};
    vecs[5] = '{"tail_2",       1'b0, tail_w, 1'b1, 2, 1'b0};
    w7[0] = make_word(56'hFE_DCBA_9876_5432, 64'h0);
    w7[1] = make_word(56'h55_5555_5555_5555, 64'h0);
    w7[2] = make_word(56'h80_0000_0000_0001, 64'h0);

    // Reset state
    bus.BitI = 1'b0;
    bus.BitValidI = 1'b0;
    RstI = 1'b0;
    #1 RstI = 1'b1;
    #1;
    check("rst_en",     bus.EnO, 1'b0);
    check("rst_data",   bus.DataO, 1'b0);
    check("rst_berr",   bus.Block_ErrO, 1'b0);
    check("rst_active", bus.CltuActiveO, 1'b0);
    check("rst_ovr",    bus.OverrunO, 1'b0);
    check("rst_cnt",    bus.BlockCntO, 16'd0);
    repeat (3) @(negedge ClkI);
    RstI = 1'b0;
    @(negedge ClkI);

    // Table: good block, tail, parity error, restart, second CLTU
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].sync) send_seq16(16'hEB90, 1);
      send_block(vecs[v].word, 1, -1, 0);
      capture_burst(vecs[v].name, vecs[v].word[63:8], vecs[v].exp_err);
      check({vecs[v].name, "_cnt"}, bus.BlockCntO, 16'(vecs[v].exp_cnt));
      check({vecs[v].name, "_active"}, bus.CltuActiveO, vecs[v].exp_active);
    end

    // Near-miss start sequences never lock; then lock after 7 random bits
    r0 = en_rises;
    send_seq16(16'hEB91, 1);
    send_seq16(16'h6B90, 1);
    for (int i = 0; i < 64; i++) send_bit(1'b0, 1);
    check("nearmiss_active", bus.CltuActiveO, 1'b0);
    check("nearmiss_no_burst", en_rises, r0);
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)), 1);
    send_seq16(16'hEB90, 1);
    check("lock_after_rand", bus.CltuActiveO, 1'b1);

    // Timeout: TO silent clocks after bit 30 abandon the CLTU, no burst
    r0 = en_rises;
    for (int i = 0; i <= 30; i++) send_bit(good_w[63-i], (i == 30) ? TO : 1);
    check("timeout_active", bus.CltuActiveO, 1'b0);
    repeat (100) @(negedge ClkI);
    check("timeout_no_burst", en_rises, r0);
    // TO-1 silent clocks then a strobe keeps the block alive
    send_seq16(16'hEB90, 1);
    send_block(good_w, 1, 30, TO - 1);
    capture_burst("pause_block", good_w[63:8], 1'b0);
    check("pause_active", bus.CltuActiveO, 1'b1);
    check("pause_cnt", bus.BlockCntO, 16'd1);
    send_block(tail_w, 1, -1, 0);
    capture_burst("pause_tail", tail_w[63:8], 1'b1);
    check("pause_tail_active", bus.CltuActiveO, 1'b0);

    // Strobe every clock: three blocks plus tail, bursts overlap reception
    ovr_cnt = 0;
    fork
      begin
        send_seq16(16'hEB90, 0);
        for (int k = 0; k < 3; k++) send_block(w7[k], 0, -1, 0);
        send_block(tail_w, 0, -1, 0);
      end
      begin
        for (int k = 0; k < 3; k++) capture_burst($sformatf("stream%0d", k), w7[k][63:8], 1'b0);
        capture_burst("stream_tail", tail_w[63:8], 1'b1);
      end
    join
    check("stream_cnt", bus.BlockCntO, 16'd3);
    check("stream_active", bus.CltuActiveO, 1'b0);
    check("stream_overrun", ovr_cnt, 0);

    // Reset mid-burst: outputs drop at once, no burst until a new start sequence
    send_seq16(16'hEB90, 1);
    send_block(good_w, 1, -1, 0);
    repeat (10) @(negedge ClkI);
    check("preburst_en", bus.EnO, 1'b1);
    #2 RstI = 1'b1;
    #1;
    check("midrst_en",     bus.EnO, 1'b0);
    check("midrst_data",   bus.DataO, 1'b0);
    check("midrst_active", bus.CltuActiveO, 1'b0);
    check("midrst_cnt",    bus.BlockCntO, 16'd0);
    @(negedge ClkI);
    RstI = 1'b0;
    @(negedge ClkI);
    r0 = en_rises;
    for (int i = 0; i < 64; i++) send_bit(1'b0, 1);
    repeat (80) @(negedge ClkI);
    check("postrst_no_burst", en_rises, r0);
    check("postrst_active", bus.CltuActiveO, 1'b0);
    send_seq16(16'hEB90, 1);
    check("postrst_relock", bus.CltuActiveO, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
